// File: rtl/seg_scan_pkg.sv
// Shared constants and timing helpers for the 4-digit segment scan driver.
package seg_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_OFF   = 2'd3;

    function automatic int slot_cycles(input int clk_hz, input int scan_hz);
        return clk_hz / (scan_hz * 4);
    endfunction

    // Active window after blanking is split into 8 brightness steps.
    function automatic int sub_cycles(input int slot_cyc, input int blank_cyc);
        return (slot_cyc - blank_cyc) / 8;
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot counter for the scan driver: cycle-in-slot, selected digit, frame tick and
// an end-of-slot strobe (high in the last cycle, so the next cycle starts a new slot).
module scan_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int SLOT_CYC = 20,
    parameter int SC_W     = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_run,
    output logic [SC_W-1:0] o_sc,
    output logic [1:0]      o_digit_idx,
    output logic            o_frame_tick,
    output logic            o_slot_end
);

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_CYC - 1);

    logic [SC_W-1:0] r_sc;
    logic [1:0]      r_digit;
    logic            r_tick;
    logic            w_last;

    assign w_last = (r_sc == SC_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sc    <= '0;
            r_digit <= 2'd0;
            r_tick  <= 1'b0;
        end else if (!i_run) begin
            r_sc    <= '0;
            r_digit <= 2'd0;
            r_tick  <= 1'b0;
        end else if (w_last) begin
            r_sc    <= '0;
            r_digit <= r_digit + 2'd1;
            r_tick  <= (r_digit == 2'd3);
        end else begin
            r_sc    <= r_sc + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    assign o_sc         = r_sc;
    assign o_digit_idx  = r_digit;
    assign o_frame_tick = r_tick;
    assign o_slot_end   = i_run & w_last;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes four active-low 7-segment patterns onto a common-anode display with
// anti-ghost blanking, 8-level PWM and a frame tick. Macro SEG_SCAN_FRAME_LATCH_EN: frame-coherent snapshot.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 500,
    parameter int BLANK_CYC = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [6:0] i_d0,
    input  logic [6:0] i_d1,
    input  logic [6:0] i_d2,
    input  logic [6:0] i_d3,
    input  logic [3:0] i_dp_in,
    input  logic [2:0] i_brightness,
    output logic [6:0] o_seg_n,
    output logic       o_dp_n,
    output logic [3:0] o_an_n,
    output logic [1:0] o_digit_idx,
    output logic       o_frame_tick
);

    localparam int SLOT_CYC = slot_cycles(CLK_HZ, SCAN_HZ);
    localparam int SUB_CYC  = sub_cycles(SLOT_CYC, BLANK_CYC);
    localparam int SC_W     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [SC_W-1:0] BLANK_LAST = SC_W'(BLANK_CYC - 1);

    // Snapshot is taken on the edge entering a slot, so at least one blank cycle is needed.
    generate
        if (SUB_CYC < 1 || BLANK_CYC < 1) begin : g_bad_cfg
            $error("seg_scan_driver: SUB_CYC must be >= 1 and BLANK_CYC >= 1");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [6:0]      r_seg_n;
    logic            r_dp_n;
    logic [3:0]      r_an_n;
    logic [SC_W-1:0] w_sc;
    logic [1:0]      w_digit;
    logic            w_slot_end;
    logic            w_run;
    logic            w_start;
    logic [1:0]      w_start_dig;
    logic [6:0]      w_pat;
    logic            w_dp;
    logic [2:0]      w_bright;
    logic [31:0]     w_on_last;

    assign w_run = i_enable & (r_state != ST_IDLE);

    scan_slot_timer #(
        .SLOT_CYC (SLOT_CYC),
        .SC_W     (SC_W)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_run        (w_run),
        .o_sc         (w_sc),
        .o_digit_idx  (w_digit),
        .o_frame_tick (o_frame_tick),
        .o_slot_end   (w_slot_end)
    );

    assign w_start     = i_enable & ((r_state == ST_IDLE) | w_slot_end);
    assign w_start_dig = (r_state == ST_IDLE) ? 2'd0 : (w_digit + 2'd1);

`ifdef SEG_SCAN_FRAME_LATCH_EN
    logic [3:0][6:0] r_frame_d;
    logic [3:0]      r_frame_dp;
    logic [2:0]      r_frame_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_d  <= {4{SEG_BLANK}};
            r_frame_dp <= 4'h0;
            r_frame_b  <= 3'd0;
        end else if (w_start && (w_start_dig == 2'd0)) begin
            r_frame_d  <= {i_d3, i_d2, i_d1, i_d0};
            r_frame_dp <= i_dp_in;
            r_frame_b  <= i_brightness;
        end
    end

    assign w_pat    = r_frame_d[w_digit];
    assign w_dp     = r_frame_dp[w_digit];
    assign w_bright = r_frame_b;
`else
    logic [6:0] r_pat_snap;
    logic       r_dp_snap;
    logic [2:0] r_bright_snap;
    logic [6:0] w_pat_sel;

    always_comb begin
        w_pat_sel = i_d0;
        case (w_start_dig)
            2'd1:    w_pat_sel = i_d1;
            2'd2:    w_pat_sel = i_d2;
            2'd3:    w_pat_sel = i_d3;
            default: w_pat_sel = i_d0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pat_snap    <= SEG_BLANK;
            r_dp_snap     <= 1'b0;
            r_bright_snap <= 3'd0;
        end else if (w_start) begin
            r_pat_snap    <= w_pat_sel;
            r_dp_snap     <= i_dp_in[w_start_dig];
            r_bright_snap <= i_brightness;
        end
    end

    assign w_pat    = r_pat_snap;
    assign w_dp     = r_dp_snap;
    assign w_bright = r_bright_snap;
`endif

    // Last sc value of the lit window for the current slot's brightness.
    assign w_on_last = 32'(BLANK_CYC) + (32'(w_bright) + 32'd1) * 32'(SUB_CYC) - 32'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_enable) w_state_nxt = ST_BLANK;
            ST_BLANK: if (w_sc == BLANK_LAST) w_state_nxt = ST_ON;
            ST_ON: begin
                if (w_slot_end)                  w_state_nxt = ST_BLANK;
                else if (32'(w_sc) == w_on_last) w_state_nxt = ST_OFF;
            end
            ST_OFF:   if (w_slot_end) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (!i_enable) w_state_nxt = ST_IDLE;
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_an_n  <= AN_OFF;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_ON) begin
                r_an_n  <= ~(4'b0001 << w_digit);
                r_seg_n <= w_pat;
                r_dp_n  <= ~w_dp;
            end else begin
                r_an_n  <= AN_OFF;
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end
        end
    end

    assign o_seg_n     = r_seg_n;
    assign o_dp_n      = r_dp_n;
    assign o_an_n      = r_an_n;
    assign o_digit_idx = w_digit;

endmodule
